// File: rtl/mem_stage.sv
// MEM stage of the five-stage MIPS pipeline: data-cache request, memory stall,
// registered MEM/WB outputs and stall/retire performance counters.
module mem_stage #(
  parameter int unsigned STALL_CNT_W = 32,
  parameter int unsigned RET_CNT_W   = 32
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   em_valid,
  input  logic                   em_hold,
  input  logic                   em_dREN,
  input  logic                   em_dWEN,
  input  logic                   em_MemtoReg,
  input  logic                   em_RegWr,
  input  logic                   em_lui,
  input  logic                   em_jal,
  input  logic                   em_halt,
  input  logic [31:0]            em_alu_out,
  input  logic [31:0]            em_rdat2,
  input  logic [31:0]            em_pcplusfour,
  input  logic [15:0]            em_imm,
  input  logic [4:0]             em_dest_reg,
  input  logic                   dhit,
  input  logic [31:0]            dmemload,
  output logic                   dmemREN,
  output logic                   dmemWEN,
  output logic [31:0]            dmemaddr,
  output logic [31:0]            dmemstore,
  output logic                   mem_stall,
  output logic                   wb_valid,
  output logic                   wb_RegWr,
  output logic                   wb_halt,
  output logic [4:0]             wb_dest_reg,
  output logic [31:0]            wb_wdat,
  output logic [STALL_CNT_W-1:0] stall_cnt,
  output logic [RET_CNT_W-1:0]   retire_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DONE   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        is_mem;
  logic        access;
  logic        complete;
  logic [31:0] wdat_sel;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    is_mem     = em_dREN | em_dWEN;
    access     = 1'b0;
    complete   = 1'b0;
    state_next = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    mem_stall  = 1'b0;
    dmemaddr   = em_alu_out;
    dmemstore  = em_rdat2;

    case (state)
      RUN: begin
        access    = em_valid & is_mem;
        complete  = em_valid & (~is_mem | dhit);
        // store wins when both enables are set
        dmemWEN   = access & em_dWEN;
        dmemREN   = access & em_dREN & ~em_dWEN;
        mem_stall = access & ~dhit;
        if (complete && em_halt)      state_next = HALTED;
        else if (complete && em_hold) state_next = DONE;
      end
      DONE: begin
        if (!em_hold) state_next = RUN;
      end
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    if (em_lui)           wdat_sel = {em_imm, 16'h0000};
    else if (em_jal)      wdat_sel = em_pcplusfour;
    else if (em_MemtoReg) wdat_sel = dmemload;
    else                  wdat_sel = em_alu_out;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wb_valid    <= 1'b0;
      wb_RegWr    <= 1'b0;
      wb_halt     <= 1'b0;
      wb_dest_reg <= '0;
      wb_wdat     <= '0;
    end else if (complete) begin
      wb_valid    <= 1'b1;
      wb_RegWr    <= em_RegWr;
      wb_dest_reg <= em_dest_reg;
      wb_wdat     <= wdat_sel;
      if (em_halt) wb_halt <= 1'b1;
    end else begin
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt  <= '0;
      retire_cnt <= '0;
    end else begin
      if (mem_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      if (complete) retire_cnt <= retire_cnt + RET_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the stage.
module tb_mem_stage;

  localparam int unsigned SW = 3;
  localparam int unsigned RW = 4;

  logic          CLK, nRST;
  logic          em_valid, em_hold, em_dREN, em_dWEN, em_MemtoReg, em_RegWr;
  logic          em_lui, em_jal, em_halt;
  logic [31:0]   em_alu_out, em_rdat2, em_pcplusfour;
  logic [15:0]   em_imm;
  logic [4:0]    em_dest_reg;
  logic          dhit;
  logic [31:0]   dmemload;
  logic          dmemREN, dmemWEN, mem_stall;
  logic [31:0]   dmemaddr, dmemstore;
  logic          wb_valid, wb_RegWr, wb_halt;
  logic [4:0]    wb_dest_reg;
  logic [31:0]   wb_wdat;
  logic [SW-1:0] stall_cnt;
  logic [RW-1:0] retire_cnt;

  mem_stage #(.STALL_CNT_W(SW), .RET_CNT_W(RW)) dut (
    .CLK(CLK), .nRST(nRST),
    .em_valid(em_valid), .em_hold(em_hold), .em_dREN(em_dREN), .em_dWEN(em_dWEN),
    .em_MemtoReg(em_MemtoReg), .em_RegWr(em_RegWr), .em_lui(em_lui), .em_jal(em_jal),
    .em_halt(em_halt), .em_alu_out(em_alu_out), .em_rdat2(em_rdat2),
    .em_pcplusfour(em_pcplusfour), .em_imm(em_imm), .em_dest_reg(em_dest_reg),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_RegWr(wb_RegWr), .wb_halt(wb_halt),
    .wb_dest_reg(wb_dest_reg), .wb_wdat(wb_wdat),
    .stall_cnt(stall_cnt), .retire_cnt(retire_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;
  int ren_cycles, wen_cycles, stall_cycles;

  // Behavioural model: "halted" and "already retired, upstream still holding".
  logic        m_halted, m_retired_held;
  logic        m_valid, m_regwr, m_whalt;
  logic [4:0]  m_dest;
  logic [31:0] m_wdat;
  int unsigned m_stall, m_ret;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_halted = 0; m_retired_held = 0;
    m_valid = 0; m_regwr = 0; m_whalt = 0; m_dest = '0; m_wdat = '0;
    m_stall = 0; m_ret = 0;
  endtask

  task automatic clear_instr();
    em_valid = 0; em_hold = 0; em_dREN = 0; em_dWEN = 0; em_MemtoReg = 0;
    em_RegWr = 0; em_lui = 0; em_jal = 0; em_halt = 0;
    em_alu_out = '0; em_rdat2 = '0; em_pcplusfour = '0; em_imm = '0; em_dest_reg = '0;
  endtask

  task automatic chk_regs();
    chk1("wb_valid", wb_valid, m_valid);
    chk1("wb_RegWr", wb_RegWr, m_regwr);
    chk1("wb_halt", wb_halt, m_whalt);
    chk32("wb_dest_reg", 32'(wb_dest_reg), 32'(m_dest));
    chk32("wb_wdat", wb_wdat, m_wdat);
    chk32("stall_cnt", 32'(stall_cnt), m_stall);
    chk32("retire_cnt", 32'(retire_cnt), m_ret);
  endtask

  // One clock: check request outputs, take the edge, check MEM/WB and counters.
  task automatic cycle();
    logic active, acc, eren, ewen, estall, comp;
    logic [31:0] wd;
    #1;
    active = !m_halted && !m_retired_held;
    acc    = active && em_valid && (em_dREN || em_dWEN);
    ewen   = acc && em_dWEN;
    eren   = acc && em_dREN && !em_dWEN;
    estall = acc && !dhit;
    comp   = active && em_valid && (!(em_dREN || em_dWEN) || dhit);
    if (em_lui)           wd = {em_imm, 16'h0000};
    else if (em_jal)      wd = em_pcplusfour;
    else if (em_MemtoReg) wd = dmemload;
    else                  wd = em_alu_out;
    chk1("dmemREN", dmemREN, eren);
    chk1("dmemWEN", dmemWEN, ewen);
    chk1("mem_stall", mem_stall, estall);
    chk32("dmemaddr", dmemaddr, em_alu_out);
    chk32("dmemstore", dmemstore, em_rdat2);
    if (dmemREN)   ren_cycles++;
    if (dmemWEN)   wen_cycles++;
    if (mem_stall) stall_cycles++;
    @(posedge CLK);
    #1;
    if (comp) begin
      m_valid = 1; m_regwr = em_RegWr; m_dest = em_dest_reg; m_wdat = wd;
      m_ret = (m_ret + 1) % (1 << RW);
    end else begin
      m_valid = 0; m_regwr = 0;
    end
    if (estall && m_stall < (1 << SW) - 1) m_stall++;
    if (comp && em_halt) begin
      m_halted = 1; m_whalt = 1;
    end else if (comp && em_hold) m_retired_held = 1;
    else if (m_retired_held && !em_hold) m_retired_held = 0;
    chk_regs();
  endtask

  task automatic apply_reset();
    nRST = 0;
    #1;
    model_reset();
    chk_regs();
    @(posedge CLK);
    #1;
    nRST = 1;
  endtask

  initial begin
    logic last_stall, last_hold;
    int unsigned ret0;
    clear_instr();
    dhit = 0; dmemload = '0;
    nRST = 0;
    model_reset();
    ren_cycles = 0; wen_cycles = 0; stall_cycles = 0;
    @(posedge CLK); @(posedge CLK); #1;
    chk_regs();
    chk1("reset_ren", dmemREN, 1'b0);
    chk1("reset_stall", mem_stall, 1'b0);
    nRST = 1;

    // Load with two wait cycles
    em_valid = 1; em_dREN = 1; em_MemtoReg = 1; em_RegWr = 1;
    em_alu_out = 32'h100; em_dest_reg = 5'd5; dhit = 0;
    cycle(); cycle();
    dhit = 1; dmemload = 32'hDEADBEEF;
    cycle();
    chk32("load_ren_cycles", 32'(ren_cycles), 32'd3);
    chk32("load_stall_cycles", 32'(stall_cycles), 32'd2);
    chk32("load_wdat", wb_wdat, 32'hDEADBEEF);
    chk1("load_valid", wb_valid, 1'b1);
    chk32("load_stall_cnt", 32'(stall_cnt), 32'd2);

    // Zero-wait store
    clear_instr();
    em_valid = 1; em_dWEN = 1; em_rdat2 = 32'h12345678; em_alu_out = 32'h200; dhit = 1;
    #1;
    chk1("store_wen", dmemWEN, 1'b1);
    chk1("store_nostall", mem_stall, 1'b0);
    cycle();
    chk1("store_valid", wb_valid, 1'b1);
    chk1("store_regwr", wb_RegWr, 1'b0);

    // Write-back select
    clear_instr(); dhit = 0;
    em_valid = 1; em_RegWr = 1; em_lui = 1; em_imm = 16'hABCD; em_alu_out = 32'h55;
    em_dest_reg = 5'd3;
    cycle();
    chk32("lui_wdat", wb_wdat, 32'hABCD0000);
    clear_instr();
    em_valid = 1; em_RegWr = 1; em_jal = 1; em_pcplusfour = 32'h44; em_dest_reg = 5'd31;
    em_alu_out = 32'h99;
    cycle();
    chk32("jal_wdat", wb_wdat, 32'h44);
    chk32("jal_dest", 32'(wb_dest_reg), 32'd31);
    clear_instr();
    em_valid = 1; em_RegWr = 1; em_alu_out = 32'h7; em_dest_reg = 5'd9;
    cycle();
    chk32("alu_wdat", wb_wdat, 32'h7);

    // Held load: retire once, three bubbles, then the next instruction
    clear_instr();
    em_valid = 1; em_dREN = 1; em_MemtoReg = 1; em_RegWr = 1; em_alu_out = 32'h300;
    em_dest_reg = 5'd7; dhit = 1; dmemload = 32'hCAFE0001; em_hold = 1;
    ren_cycles = 0; ret0 = 32'(retire_cnt);
    cycle();
    cycle(); chk1("hold_bubble1", wb_valid, 1'b0);
    cycle(); chk1("hold_bubble2", wb_valid, 1'b0);
    em_hold = 0;
    cycle(); chk1("hold_bubble3", wb_valid, 1'b0);
    chk32("hold_ren_pulses", 32'(ren_cycles), 32'd1);
    chk32("hold_retires", (32'(retire_cnt) - ret0) % (1 << RW), 32'd1);
    clear_instr();
    em_valid = 1; em_RegWr = 1; em_alu_out = 32'h8; em_dest_reg = 5'd2;
    cycle();
    chk1("after_hold_valid", wb_valid, 1'b1);

    // Halt on a non-access instruction
    clear_instr();
    em_valid = 1; em_halt = 1;
    cycle();
    chk1("halt_set", wb_halt, 1'b1);
    ret0 = 32'(retire_cnt);
    clear_instr();
    em_valid = 1; em_dREN = 1; em_alu_out = 32'h400; dhit = 0;
    ren_cycles = 0;
    cycle(); cycle();
    chk32("halt_no_ren", 32'(ren_cycles), 32'd0);
    chk32("halt_retire_frozen", 32'(retire_cnt), ret0);
    chk1("halt_sticky", wb_halt, 1'b1);

    // Reset during the second stall cycle
    apply_reset();
    clear_instr();
    em_valid = 1; em_dREN = 1; em_MemtoReg = 1; em_RegWr = 1; em_alu_out = 32'h500;
    em_dest_reg = 5'd4; dhit = 0;
    cycle();
    #1;
    chk1("midwait_stall", mem_stall, 1'b1);
    nRST = 0;
    #1;
    model_reset();
    chk_regs();
    em_valid = 0;
    #1;
    chk1("midwait_ren_drop", dmemREN, 1'b0);
    chk1("midwait_stall_drop", mem_stall, 1'b0);
    @(posedge CLK); #1;
    nRST = 1;
    clear_instr();
    em_valid = 1; em_RegWr = 1; em_alu_out = 32'h11; em_dest_reg = 5'd1;
    cycle();
    chk1("post_reset_run", wb_valid, 1'b1);

    // Randomized traffic
    last_stall = 0; last_hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (m_halted && ($urandom % 8 == 0)) begin
        apply_reset();
        last_stall = 0; last_hold = 0;
      end
      if (!last_stall && !last_hold) begin
        int unsigned kind;
        clear_instr();
        kind = $urandom % 4;
        em_valid      = ($urandom % 4) != 0;
        em_dREN       = (kind == 0) || ($urandom % 16 == 0);
        em_dWEN       = (kind == 1);
        em_MemtoReg   = (kind == 0) ? 1'b1 : 1'($urandom % 8 == 0);
        em_RegWr      = 1'($urandom);
        em_lui        = (kind == 3) && ($urandom % 2 == 0);
        em_jal        = (kind == 3) && ($urandom % 2 == 0);
        em_halt       = ($urandom % 120 == 0);
        em_alu_out    = $urandom;
        em_rdat2      = $urandom;
        em_pcplusfour = $urandom;
        em_imm        = 16'($urandom);
        em_dest_reg   = 5'($urandom);
      end
      em_hold  = ($urandom % 4 == 0);
      dhit     = 1'($urandom);
      dmemload = $urandom;
      #1;
      last_stall = mem_stall;
      last_hold  = em_hold;
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the five-stage MIPS pipeline. Consumes the EX/MEM latch outputs and drives the datapath-side data-cache request, holding it until `dhit`. Stalls the front of the pipeline while an access is outstanding and produces the registered MEM/WB outputs: write-back data, destination, write enable, halt. Also keeps two performance counters: memory-stall cycles and retired instructions.

## Interface
Parameters:
- `STALL_CNT_W`, default 32: width of the stall-cycle counter, which saturates.
- `RET_CNT_W`, default 32: width of the retired-instruction counter, which wraps.

Ports:
- `CLK` in 1: the single clock. All state updates on its rising edge.
- `nRST` in 1: reset, asynchronous and active-low.
- `em_valid` in 1: the EX/MEM latch holds a real instruction (not a bubble).
- `em_hold` in 1: the hazard unit is freezing EX/MEM this cycle.
- `em_dREN`, `em_dWEN` in 1 each: the instruction is a load / store.
- `em_MemtoReg`, `em_RegWr`, `em_lui`, `em_jal`, `em_halt` in 1 each: control bits.
- `em_alu_out` in 32: ALU result; also the memory address.
- `em_rdat2` in 32: store data.
- `em_pcplusfour` in 32: link value for `jal`.
- `em_imm` in 16: immediate for `lui`.
- `em_dest_reg` in 5: destination register, already resolved upstream (31 for `jal`).
- `dhit` in 1: data cache completed the request this cycle.
- `dmemload` in 32: load data, valid when `dhit`.
- `dmemREN`, `dmemWEN` out 1 each: data request to the cache.
- `dmemaddr`, `dmemstore` out 32 each: request address and store data.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX and EX/MEM.
- `wb_valid`, `wb_RegWr`, `wb_halt` out 1 each: MEM/WB control.
- `wb_dest_reg` out 5.
- `wb_wdat` out 32.
- `stall_cnt` out `STALL_CNT_W`.
- `retire_cnt` out `RET_CNT_W`.

## Operation
- FSM states: RUN, DONE, HALTED.
- Access instruction: `em_valid & (em_dREN | em_dWEN)` in state RUN.
- Request outputs (combinational):
  - `dmemWEN = access & em_dWEN`.
  - `dmemREN = access & em_dREN & ~em_dWEN`. Write has priority; both set is illegal and is treated as a store.
  - `dmemaddr = em_alu_out` and `dmemstore = em_rdat2` at all times.
- Stall and completion:
  - `mem_stall = access & ~dhit`.
  - An instruction completes in RUN when `em_valid` and either it is a non-access, or it is an access with `dhit`.
- Write-back data, priority order:
  1. `em_lui`: `{em_imm, 16'h0000}`.
  2. `em_jal`: `em_pcplusfour`.
  3. `em_MemtoReg`: `dmemload`.
  4. Otherwise: `em_alu_out`.
- On completion: MEM/WB loads `wb_valid=1`, `wb_RegWr=em_RegWr`, `wb_dest_reg`, `wb_wdat`, and `retire_cnt` increments.
- Every edge with no completion loads a bubble: `wb_valid=0`, `wb_RegWr=0`. `wb_dest_reg` and `wb_wdat` hold their values.
- Transitions from RUN:
  - Completion with `em_halt`: go to HALTED.
  - Completion with `em_hold=1`: go to DONE. EX/MEM will present the same instruction again.
  - Otherwise: stay in RUN.
- DONE: no request, no stall, bubbles only. Go to RUN on the first edge with `em_hold=0`. This means a held instruction is never re-issued to the cache and never retired twice.
- HALTED:
  - `wb_halt=1` is sticky until reset.
  - Requests are suppressed, `mem_stall=0`, bubbles only.
  - `retire_cnt` and `stall_cnt` freeze.
- `stall_cnt` increments on every edge with `mem_stall=1` and saturates at all-ones.

## Timing
- Reset (`nRST=0`, asynchronous):
  - State goes to RUN.
  - All `wb_*` outputs go to 0; both counters go to 0.
  - `dmemREN`, `dmemWEN` and `mem_stall` follow the combinational equations, so they go low whenever `em_valid=0`.
- Latency from `dhit` to write-back:
  - A zero-wait access (`dhit` in the same cycle as the request) completes at the next edge with no stall.
  - An access with N wait cycles asserts `mem_stall` for exactly N cycles.
  - In both cases the write-back is visible one cycle after `dhit`.
- The request stays high and stable for every cycle up to and including the `dhit` cycle.
- `dhit` while in DONE or HALTED is ignored.
- Reset asserted mid-access drops the request once the upstream latch clears. No write-back occurs for the aborted instruction.

## Test plan
- Load: `em_alu_out=0x100`, `dhit` low for 2 cycles, then `dmemload=0xDEADBEEF`.
  - `dmemREN` high for 3 cycles; `mem_stall` high for 2 cycles.
  - Next cycle: `wb_wdat=0xDEADBEEF`, `wb_valid=1`, `stall_cnt=2`.
- Zero-wait store: `em_rdat2=0x12345678` with `dhit` in the same cycle.
  - `dmemWEN=1`, `mem_stall=0`.
  - Next cycle: `wb_valid=1`, `wb_RegWr=0`.
- Write-back select:
  - `lui` with `em_imm=0xABCD` gives `0xABCD0000`.
  - `jal` with `em_pcplusfour=0x44` gives `0x44`, `wb_dest_reg=31`.
  - ALU op with result `0x7` gives `0x7`.
- Hold after a completed load: `em_hold=1` for 3 cycles.
  - Exactly one `dmemREN` pulse and one retire.
  - 3 cycles of bubbles, then the next instruction proceeds.
- Halt: `em_halt` on a non-access instruction.
  - `wb_halt=1` from the next cycle onward.
  - A following load produces no `dmemREN`.
  - `retire_cnt` frozen.
- Reset mid-wait: drop `nRST` during the second stall cycle.
  - All `wb_*` outputs and both counters read 0 immediately.
  - State is RUN after release.
